// File: rtl/hs_sync_sink.sv
// Clocked sink for one branch of a 4-phase bundled-data split: synchronises the request,
// captures the bundled word into a FIFO and presents it as a first-word-fall-through stream.
module hs_sync_sink #(
  parameter int WIDTH       = 8,
  parameter int DEPTH       = 4,
  parameter int SYNC_STAGES = 2
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     r_i,
  output logic                     a_i,
  input  logic [WIDTH-1:0]         d_i,
  output logic [WIDTH-1:0]         dout,
  output logic                     valid_o,
  input  logic                     ready_i,
  output logic [$clog2(DEPTH):0]   count_o
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  typedef enum logic {IDLE = 1'b0, ACK = 1'b1} state_t;

  state_t                  state_q;
  logic                    ack_q;
  logic [SYNC_STAGES-1:0]  sync_q;
  logic                    r_s;
  logic [WIDTH-1:0]        mem [DEPTH];
  logic [AW-1:0]           wr_ptr;
  logic [AW-1:0]           rd_ptr;
  logic [CW-1:0]           count_q;
  logic                    full;
  logic                    push;
  logic                    pop;

  // r_i is asynchronous; d_i is never synchronised and is only sampled once r_s
  // has seen the request, by which time bundling guarantees it is stable.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sync_q <= '0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], r_i};
    end
  end

  assign r_s  = sync_q[SYNC_STAGES-1];
  assign full = (count_q == CW'(DEPTH));

  // Output stream: a word transfers on every rising edge where valid_o and ready_i
  // are both high; dout is held while valid_o=1 and ready_i=0, ready_i with valid_o=0 is ignored.
  assign pop  = (count_q != '0) && ready_i;
  // A pop on the same edge frees a slot, so a full FIFO may still capture.
  assign push = (state_q == IDLE) && r_s && (!full || pop);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      ack_q   <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (push) begin
            state_q <= ACK;
            ack_q   <= 1'b1;
          end
        end
        ACK: begin
          if (!r_s) begin
            state_q <= IDLE;
            ack_q   <= 1'b0;
          end
        end
        default: begin
          state_q <= IDLE;
          ack_q   <= 1'b0;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem[i] <= '0;
      end
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count_q <= '0;
    end else begin
      if (push) begin
        mem[wr_ptr] <= d_i;
        wr_ptr      <= wr_ptr + 1'b1;
      end
      if (pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      case ({push, pop})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
    end
  end

  assign a_i     = ack_q;
  assign dout    = mem[rd_ptr];
  assign valid_o = (count_q != '0);
  assign count_o = count_q;

endmodule
